// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for
// the MIPS-subset datapath, with illegal-instruction and memory-timeout traps.
// Optional build macro: CTRL_PERF_CNT_EN enables the cycle_cnt/instr_cnt
// performance counters; without it both ports are tied to zero.
module mc_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             we_dmem,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [3:0]       alu_op,
   output logic             alu_src,
   output logic             we_regfile,
   output logic             sel_dmem,
   output logic             rdst_sel,
   output logic             retire,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // Last wait-count value before the trap fires; unused when TIMEOUT is 0.
   localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT) - 32'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   state_t      state;
   logic [5:0]  op_q;
   logic [5:0]  fn_q;
   logic [31:0] wait_cnt;
   logic        wait_expired;

   // Opcodes (other than j) that proceed to EXEC.
   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_R:                                 ok = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
         OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Returns {alu_src, alu_op} for a latched instruction.
   function automatic logic [4:0] alu_dec(input logic [5:0] op, input logic [5:0] fn);
      logic [4:0] r;
      r = '0;
      case (op)
         OP_R: begin
            case (fn)
               FN_ADD:  r = {1'b0, ALU_ADD};
               FN_SUB:  r = {1'b0, ALU_SUB};
               FN_AND:  r = {1'b0, ALU_AND};
               FN_OR:   r = {1'b0, ALU_OR};
               FN_NOR:  r = {1'b0, ALU_NOR};
               FN_SLT:  r = {1'b0, ALU_SLT};
               default: r = '0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: r = {1'b1, ALU_ADD};
         OP_SLTI:               r = {1'b1, ALU_SLT};
         OP_BEQ:                r = {1'b0, ALU_SUB};
         default:               r = '0;
      endcase
      return r;
   endfunction

   assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

   // Strobes decoded from the current state, latched instruction and readys.
   // DECODE uses the live opcode because the latch only settles at its end.
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      we_dmem    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'd0;
      alu_op     = '0;
      alu_src    = 1'b0;
      we_regfile = 1'b0;
      sel_dmem   = 1'b0;
      rdst_sel   = 1'b0;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
         end
         S_DECODE: begin
            if (opcode == OP_J) begin
               pc_we  = 1'b1;
               pc_sel = 2'd2;
               retire = 1'b1;
            end
         end
         S_EXEC: begin
            {alu_src, alu_op} = alu_dec(op_q, fn_q);
            if (op_q == OP_BEQ) begin
               retire = 1'b1;
               if (zero) begin
                  pc_we  = 1'b1;
                  pc_sel = 2'd1;
               end
            end
         end
         S_MEM: begin
            {alu_src, alu_op} = alu_dec(op_q, fn_q);
            dmem_req = 1'b1;
            we_dmem  = (op_q == OP_SW);
            retire   = dmem_ready && (op_q == OP_SW);
         end
         S_WB: begin
            {alu_src, alu_op} = alu_dec(op_q, fn_q);
            we_regfile = 1'b1;
            rdst_sel   = (op_q == OP_R);
            sel_dmem   = (op_q == OP_LW);
            retire     = 1'b1;
         end
         default: ;
      endcase
   end

   // Sequencer state, instruction latch, memory wait counter and trap status.
   // wait_cnt is zero on every entry to FETCH/MEM because each exit path clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         op_q       <= '0;
         fn_q       <= '0;
         wait_cnt   <= '0;
         trap       <= 1'b0;
         trap_cause <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state    <= S_DECODE;
                  wait_cnt <= '0;
               end else if (wait_expired) begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            S_DECODE: begin
               op_q <= opcode;
               fn_q <= funct;
               if (opcode == OP_J) begin
                  state <= run ? S_FETCH : S_IDLE;
               end else if (is_legal(opcode, funct)) begin
                  state <= S_EXEC;
               end else begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_ILLEGAL;
               end
            end
            S_EXEC: begin
               if (op_q == OP_BEQ)                        state <= run ? S_FETCH : S_IDLE;
               else if ((op_q == OP_LW) || (op_q == OP_SW)) state <= S_MEM;
               else                                       state <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  wait_cnt <= '0;
                  if (op_q == OP_SW) state <= run ? S_FETCH : S_IDLE;
                  else               state <= S_WB;
               end else if (wait_expired) begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= CAUSE_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            S_WB: begin
               state <= run ? S_FETCH : S_IDLE;
            end
            S_TRAP: ;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   // Saturating busy-cycle and retired-instruction counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if ((state != S_IDLE) && (state != S_TRAP) && (cycle_cnt != '1))
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire && (instr_cnt != '1))
            instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`else
   // Counters absent: ports held at zero.
   always_comb begin
      cycle_cnt = '0;
      instr_cnt = '0;
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed scoreboard bench for mc_ctrl_fsm (TIMEOUT=4).
module tb_mc_ctrl_fsm;

   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          run = 1'b0;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic          zero = 1'b0;
   logic          imem_ready;
   logic          dmem_ready;
   logic          imem_req, dmem_req, we_dmem, ir_we, pc_we;
   logic [1:0]    pc_sel;
   logic [3:0]    alu_op;
   logic          alu_src, we_regfile, sel_dmem, rdst_sel, retire, trap;
   logic [1:0]    trap_cause;
   logic [CW-1:0] cycle_cnt, instr_cnt;
   logic [18:0]   outs;
   logic [15:0]   strobes;

   mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .we_dmem(we_dmem),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op),
      .alu_src(alu_src), .we_regfile(we_regfile), .sel_dmem(sel_dmem),
      .rdst_sel(rdst_sel), .retire(retire), .trap(trap),
      .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign outs    = {imem_req, dmem_req, we_dmem, ir_we, pc_we, pc_sel, alu_op,
                     alu_src, we_regfile, sel_dmem, rdst_sel, retire, trap, trap_cause};
   assign strobes = outs[18:3];

   typedef struct packed {
      int         lat;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       we_regfile;
      logic       sel_dmem;
      logic       rdst_sel;
      logic       chk_alu;
      logic [3:0] alu_op;
      logic       alu_src;
      logic       wd;
      int         dcyc;
   } exp_t;

   exp_t  sb[$];
   string sbn[$];
   int    checks = 0;
   int    errors = 0;
   int    imem_delay = 0;
   int    dmem_delay = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int lat, input logic pcwe, input logic [1:0] pcsel,
                               input logic wr, input logic seld, input logic rdst,
                               input logic chka, input logic [3:0] aop, input logic asrc,
                               input logic wd, input int dcyc);
      exp_t e;
      e.lat = lat; e.pc_we = pcwe; e.pc_sel = pcsel; e.we_regfile = wr;
      e.sel_dmem = seld; e.rdst_sel = rdst; e.chk_alu = chka; e.alu_op = aop;
      e.alu_src = asrc; e.wd = wd; e.dcyc = dcyc;
      return e;
   endfunction

   // Instruction memory model: ready after imem_delay waiting cycles.
   initial begin : imem_resp
      int icnt;
      icnt = 0;
      imem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            imem_ready = (icnt >= imem_delay);
            icnt++;
         end else begin
            icnt = 0;
            imem_ready = 1'b0;
         end
      end
   end

   // Data memory model: done after dmem_delay waiting cycles.
   initial begin : dmem_resp
      int dcnt;
      dcnt = 0;
      dmem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (dmem_req) begin
            dmem_ready = (dcnt >= dmem_delay);
            dcnt++;
         end else begin
            dcnt = 0;
            dmem_ready = 1'b0;
         end
      end
   end

   // Monitor: tracks each instruction from its first fetch cycle and checks
   // the scoreboard entry whenever the DUT signals retire.
   initial begin : monitor
      bit    in_instr;
      bit    wd;
      int    cyc, dcyc, ircnt;
      exp_t  e;
      string nm;
      in_instr = 0; wd = 0; cyc = 0; dcyc = 0; ircnt = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rstn !== 1'b1) begin
            in_instr = 0;
            continue;
         end
         if (!in_instr && imem_req === 1'b1) begin
            in_instr = 1; cyc = 0; dcyc = 0; ircnt = 0; wd = 0;
         end
         if (in_instr) begin
            cyc++;
            if (dmem_req === 1'b1) dcyc++;
            if (ir_we === 1'b1) ircnt++;
            if (we_dmem === 1'b1) wd = 1;
         end
         if (retire === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_retire", 32'(retire), 32'd0);
            end else begin
               e  = sb.pop_front();
               nm = sbn.pop_front();
               chk({nm, "_latency"}, 32'(cyc), 32'(e.lat));
               chk({nm, "_pc_we"}, 32'(pc_we), 32'(e.pc_we));
               if (e.pc_we) chk({nm, "_pc_sel"}, 32'(pc_sel), 32'(e.pc_sel));
               chk({nm, "_we_regfile"}, 32'(we_regfile), 32'(e.we_regfile));
               chk({nm, "_sel_dmem"}, 32'(sel_dmem), 32'(e.sel_dmem));
               chk({nm, "_rdst_sel"}, 32'(rdst_sel), 32'(e.rdst_sel));
               if (e.chk_alu) begin
                  chk({nm, "_alu_op"}, 32'(alu_op), 32'(e.alu_op));
                  chk({nm, "_alu_src"}, 32'(alu_src), 32'(e.alu_src));
               end
               chk({nm, "_we_dmem_seen"}, 32'(wd), 32'(e.wd));
               chk({nm, "_dmem_req_cycles"}, 32'(dcyc), 32'(e.dcyc));
               chk({nm, "_ir_we_pulses"}, 32'(ircnt), 32'd1);
            end
            in_instr = 0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      run  = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Raise run in IDLE; returns just after the edge that enters FETCH.
   task automatic start_run();
      run = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Called just after the edge entering FETCH; returns just after the edge
   // that begins the next instruction (or IDLE when last is set).
   task automatic issue(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int idel, input int ddel,
                        input exp_t e, input bit last);
      opcode = op; funct = fn; zero = z;
      imem_delay = idel; dmem_delay = ddel;
      sb.push_back(e);
      sbn.push_back(nm);
      if (last) run = 1'b0;
      repeat (e.lat) @(posedge clk);
      #1;
   endtask

   task automatic illegal_case(input string nm, input logic [5:0] op, input logic [5:0] fn);
      int          rcnt;
      logic [15:0] sacc;
      rcnt = 0;
      sacc = '0;
      do_reset();
      opcode = op; funct = fn; imem_delay = 0;
      start_run();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (retire === 1'b1) rcnt++;
         if (i >= 2) sacc = sacc | strobes;
      end
      chk({nm, "_trap"}, 32'(trap), 32'd1);
      chk({nm, "_trap_cause"}, 32'(trap_cause), 32'd1);
      chk({nm, "_strobes_in_trap"}, 32'(sacc), 32'd0);
      chk({nm, "_retire_count"}, 32'(rcnt), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin : stim
      int   cnt;
      logic acc;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", 32'(outs), 32'd0);
      chk("reset_cycle_cnt", cycle_cnt, 32'd0);
      chk("reset_instr_cnt", instr_cnt, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_without_run", 32'(imem_req), 32'd0);

      // Instruction stream with run held high
      start_run();
      issue("add",  6'h00, 6'h20, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b0010, 0, 0, 0), 0);
      issue("sub",  6'h00, 6'h22, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b0110, 0, 0, 0), 0);
      issue("and",  6'h00, 6'h24, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b0000, 0, 0, 0), 0);
      issue("or",   6'h00, 6'h25, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b0001, 0, 0, 0), 0);
      issue("nor",  6'h00, 6'h27, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b1100, 0, 0, 0), 0);
      issue("slt",  6'h00, 6'h2A, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 1, 1, 4'b0111, 0, 0, 0), 0);
      issue("addi", 6'h08, 6'h00, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 0, 1, 4'b0010, 1, 0, 0), 0);
      issue("slti", 6'h0A, 6'h00, 1'b0, 0, 0, mk(4, 0, 2'd0, 1, 0, 0, 1, 4'b0111, 1, 0, 0), 0);
      issue("sw",   6'h2B, 6'h00, 1'b0, 0, 0, mk(4, 0, 2'd0, 0, 0, 0, 1, 4'b0010, 1, 1, 1), 0);
      issue("lw",   6'h23, 6'h00, 1'b0, 0, 3, mk(8, 0, 2'd0, 1, 1, 0, 1, 4'b0010, 1, 0, 4), 0);
      issue("beq_t", 6'h04, 6'h00, 1'b1, 0, 0, mk(3, 1, 2'd1, 0, 0, 0, 1, 4'b0110, 0, 0, 0), 0);
      issue("beq_n", 6'h04, 6'h00, 1'b0, 0, 0, mk(3, 0, 2'd0, 0, 0, 0, 1, 4'b0110, 0, 0, 0), 0);
      issue("j",    6'h02, 6'h00, 1'b0, 0, 0, mk(2, 1, 2'd2, 0, 0, 0, 0, 4'b0000, 0, 0, 0), 0);
      // Fetch ready on the 4th wait cycle; run drops mid-instruction
      issue("j_slow", 6'h02, 6'h00, 1'b0, 3, 0, mk(5, 1, 2'd2, 0, 0, 0, 0, 4'b0000, 0, 0, 0), 1);
      acc = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         acc = acc | imem_req;
      end
      chk("idle_after_run_drop", 32'(acc), 32'd0);
      chk("ready_beats_timeout", 32'(trap), 32'd0);

      // Illegal instructions
      illegal_case("illegal_op3f", 6'h3F, 6'h00);
      illegal_case("illegal_funct01", 6'h00, 6'h01);

      // Reset mid-FETCH drops the request immediately
      do_reset();
      imem_delay = 100;
      start_run();
      chk("fetch_req_before_rst", 32'(imem_req), 32'd1);
      #3;
      rstn = 1'b0;
      #1;
      chk("rst_drops_imem_req", 32'(imem_req), 32'd0);
      chk("rst_outputs_zero", 32'(outs), 32'd0);

      // Fetch timeout
      do_reset();
      imem_delay = 100;
      opcode = 6'h00; funct = 6'h20;
      start_run();
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (imem_req === 1'b1) cnt++;
      end
      chk("timeout_fetch_cycles", 32'(cnt), 32'd4);
      chk("timeout_trap", 32'(trap), 32'd1);
      chk("timeout_cause", 32'(trap_cause), 32'd2);

      // Two jumps then run low: counters
      do_reset();
      imem_delay = 0;
      opcode = 6'h02; funct = 6'h00; zero = 1'b0;
      sb.push_back(mk(2, 1, 2'd2, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
      sbn.push_back("cnt_j1");
      sb.push_back(mk(2, 1, 2'd2, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
      sbn.push_back("cnt_j2");
      start_run();
      repeat (3) @(posedge clk);
      #1;
      run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cnt_idle_imem_req", 32'(imem_req), 32'd0);
      chk("cnt_no_trap", 32'(trap), 32'd0);
`ifdef CTRL_PERF_CNT_EN
      chk("instr_cnt", instr_cnt, 32'd2);
      chk("cycle_cnt", cycle_cnt, 32'd4);
`else
      chk("instr_cnt_tied", instr_cnt, 32'd0);
      chk("cycle_cnt_tied", cycle_cnt, 32'd0);
`endif

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
